// File: rtl/md_defs.sv
// rtl/md_defs.sv - shared MD operation codes and default latencies
// Purpose: operation encoding of the execute-stage multiply/divide unit and
//          its default busy latencies.
// Ports:   none (package).
package md_defs;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  // Busy cycles following the start cycle; the 4-bit busy counter caps
  // both at 15, and a value of 0 would never commit a result.
  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  function automatic logic is_md_arith(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_md_unit.sv
// rtl/e_md_unit.sv - execute-stage multiply/divide unit owning HI/LO
// Purpose: runs mult/multu/div/divu with fixed multi-cycle latency and serves
//          mfhi/mflo/mthi/mtlo. The result is computed at start, parked in
//          hi_tmp/lo_tmp and committed to HI/LO on the last busy edge.
// Ports:
//   clk      - pipeline clock
//   reset    - synchronous active-high reset
//   req      - flush of the E-stage instruction this cycle
//   md_op    - MD operation of the E-stage instruction (md_defs codes)
//   rs_val   - forwarded rs operand
//   rt_val   - forwarded rt operand
//   md_start - E instruction is mult/multu/div/divu and not flushed
//   md_busy  - remaining busy cycles, nonzero while busy
//   md_rd    - HI for mfhi, LO for mflo, else 0
module e_md_unit
  import md_defs::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        md_start,
  output logic [3:0]  md_busy,
  output logic [31:0] md_rd
);

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  logic [3:0]  cnt;
  logic [31:0] hi, lo;
  logic [31:0] hi_tmp, lo_tmp;
  logic [31:0] res_hi, res_lo;
  logic        is_mult_op;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] den_s;
  logic signed [31:0] quo_s, rem_s;
  logic        [31:0] den_u;
  logic        [31:0] quo_u, rem_u;
  logic               div_zero, div_ovf;

  assign md_start   = is_md_arith(md_op) && !req;
  assign is_mult_op = (md_op == MD_MULT) || (md_op == MD_MULTU);
  assign md_busy    = cnt;

  always_comb begin
    md_rd = 32'd0;
    if (md_op == MD_MFHI) md_rd = hi;
    else if (md_op == MD_MFLO) md_rd = lo;
  end

  // Divisors are forced to 1 for the zero and 0x80000000/-1 cases so the
  // dividers never see an undefined operation; zero-divide then keeps HI/LO,
  // and the overflow case yields quotient 0x80000000, remainder 0 for free.
  always_comb begin
    prod_s   = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    prod_u   = {32'd0, rs_val} * {32'd0, rt_val};
    div_zero = (rt_val == 32'd0);
    div_ovf  = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);
    den_s    = (div_zero || div_ovf) ? 32'sd1 : $signed(rt_val);
    den_u    = div_zero ? 32'd1 : rt_val;
    quo_s    = $signed(rs_val) / den_s;
    rem_s    = $signed(rs_val) % den_s;
    quo_u    = rs_val / den_u;
    rem_u    = rs_val % den_u;

    res_hi = hi;
    res_lo = lo;
    case (md_op)
      MD_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MD_DIV: begin
        if (!div_zero) begin
          res_hi = rem_s;
          res_lo = quo_s;
        end
      end
      MD_DIVU: begin
        if (!div_zero) begin
          res_hi = rem_u;
          res_lo = quo_u;
        end
      end
      default: ;
    endcase
  end

  // While busy, new starts and mthi/mtlo are ignored so the in-flight
  // result always wins; req only gates what enters from the E stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= 4'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      hi_tmp <= 32'd0;
      lo_tmp <= 32'd0;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        hi <= hi_tmp;
        lo <= lo_tmp;
      end
    end else if (md_start) begin
      hi_tmp <= res_hi;
      lo_tmp <= res_lo;
      cnt    <= is_mult_op ? MULT_LAT : DIV_LAT;
    end else if (!req) begin
      if (md_op == MD_MTHI) hi <= rs_val;
      if (md_op == MD_MTLO) lo <= rs_val;
    end
  end

endmodule

// File: tb/tb_e_md_unit.sv
// tb/tb_e_md_unit.sv - self-checking bench for e_md_unit
module tb_e_md_unit;
  import md_defs::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [3:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        md_start;
  logic [3:0]  md_busy;
  logic [31:0] md_rd;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi, m_lo;

  e_md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .req(req), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val),
    .md_start(md_start), .md_busy(md_busy), .md_rd(md_rd)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sp, q, r;
    longint unsigned up, uq, ur;
    case (op)
      MD_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        m_hi = sp[63:32]; m_lo = sp[31:0];
      end
      MD_MULTU: begin
        up = longint'({32'd0, a}) * longint'({32'd0, b});
        m_hi = up[63:32]; m_lo = up[31:0];
      end
      MD_DIV: if (b != 0) begin
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) - q * longint'($signed(b));
        m_hi = r[31:0]; m_lo = q[31:0];
      end
      MD_DIVU: if (b != 0) begin
        uq = longint'({32'd0, a}) / longint'({32'd0, b});
        ur = longint'({32'd0, a}) % longint'({32'd0, b});
        m_hi = ur[31:0]; m_lo = uq[31:0];
      end
      default: ;
    endcase
  endtask

  task automatic check_hilo(input string name);
    logic [31:0] h, l;
    logic [3:0] saved;
    saved = md_op;
    md_op = MD_MFHI; #1; h = md_rd;
    md_op = MD_MFLO; #1; l = md_rd;
    md_op = saved; #1;
    checks++;
    if (h !== m_hi) begin
      errors++;
      $display("FAIL %s_hi: got %h expected %h", name, h, m_hi);
    end
    checks++;
    if (l !== m_lo) begin
      errors++;
      $display("FAIL %s_lo: got %h expected %h", name, l, m_lo);
    end
  endtask

  // Issue one arithmetic op, check start/busy countdown, then HI/LO.
  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    int n;
    n = (op == MD_MULT || op == MD_MULTU) ? MULT_N : DIV_N;
    md_op = op; rs_val = a; rt_val = b; req = 1'b0;
    #1;
    checks++;
    if (md_start !== 1'b1) begin
      errors++;
      $display("FAIL %s_start: got %b expected 1", name, md_start);
    end
    step();
    model_apply(op, a, b);
    md_op = MD_NONE; rs_val = $urandom; rt_val = $urandom;
    for (int k = n; k >= 1; k--) begin
      #1;
      checks++;
      if (md_busy !== 4'(k)) begin
        errors++;
        $display("FAIL %s_busy: got %0d expected %0d", name, md_busy, k);
      end
      step();
    end
    checks++;
    if (md_busy !== 4'd0) begin
      errors++;
      $display("FAIL %s_idle: got %0d expected 0", name, md_busy);
    end
    check_hilo(name);
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; md_op = MD_NONE; rs_val = 0; rt_val = 0;
    step(); step();
    reset = 1'b0;
    m_hi = 0; m_lo = 0;
    #1;
    checks++;
    if (md_busy !== 4'd0 || md_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: busy %0d start %b expected 0 0", md_busy, md_start);
    end
    check_hilo("reset");
  endtask

  task automatic test_directed();
    run_op("mult_neg", MD_MULT, 32'hFFFF_FFFE, 32'd3);
    checks++;
    if (m_hi !== 32'hFFFF_FFFF || m_lo !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL model_mult: got %h_%h expected ffffffff_fffffffa", m_hi, m_lo);
    end
    run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_zero", MD_DIVU, 32'd7, 32'd0);
    run_op("div_zero", MD_DIV, 32'h1234, 32'd0);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
  endtask

  task automatic test_req_suppress();
    md_op = MD_MULT; rs_val = 32'd9; rt_val = 32'd9; req = 1'b1;
    #1;
    checks++;
    if (md_start !== 1'b0) begin
      errors++;
      $display("FAIL req_start: got %b expected 0", md_start);
    end
    step();
    md_op = MD_MTHI; rs_val = 32'hDEAD_BEEF;
    step();
    req = 1'b0; md_op = MD_NONE;
    #1;
    checks++;
    if (md_busy !== 4'd0) begin
      errors++;
      $display("FAIL req_busy: got %0d expected 0", md_busy);
    end
    check_hilo("req");
  endtask

  task automatic test_mthi_reset();
    md_op = MD_MTHI; rs_val = 32'h1234_5678; req = 1'b0;
    step();
    m_hi = 32'h1234_5678;
    md_op = MD_NONE;
    check_hilo("mthi");
    md_op = MD_DIV; rs_val = 32'd100; rt_val = 32'd7;
    step();
    md_op = MD_MTLO; rs_val = 32'hAAAA_5555;
    step(); step(); step();
    checks++;
    if (md_busy !== 4'd7) begin
      errors++;
      $display("FAIL abort_busy4: got %0d expected 7", md_busy);
    end
    reset = 1'b1;
    step();
    reset = 1'b0; md_op = MD_NONE;
    m_hi = 0; m_lo = 0;
    #1;
    checks++;
    if (md_busy !== 4'd0) begin
      errors++;
      $display("FAIL abort_busy: got %0d expected 0", md_busy);
    end
    check_hilo("abort");
  endtask

  task automatic test_busy_ignore();
    logic [31:0] a, b;
    a = 32'd1000; b = 32'd3;
    md_op = MD_DIVU; rs_val = a; rt_val = b; req = 1'b0;
    step();
    model_apply(MD_DIVU, a, b);
    md_op = MD_MTLO; rs_val = 32'h5A5A_5A5A;
    step();
    md_op = MD_MULT; rs_val = 32'd2; rt_val = 32'd2;
    #1;
    checks++;
    if (md_start !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_decode: got %b expected 1", md_start);
    end
    step();
    md_op = MD_NONE;
    for (int k = 0; k < DIV_N; k++) step();
    checks++;
    if (md_busy !== 4'd0) begin
      errors++;
      $display("FAIL busy_ignore_idle: got %0d expected 0", md_busy);
    end
    check_hilo("busy_ignore");
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(1, 4));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) b = 0;
      if ($urandom_range(0, 5) == 0) b = $urandom_range(1, 9);
      run_op("rand", op, a, b);
      if ($urandom_range(0, 1) == 1) begin
        a = $urandom;
        op = ($urandom_range(0, 1) == 1) ? MD_MTHI : MD_MTLO;
        md_op = op; rs_val = a;
        step();
        if (op == MD_MTHI) m_hi = a; else m_lo = a;
        md_op = MD_NONE;
        check_hilo("rand_mt");
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_req_suppress();
    test_mthi_reset();
    test_busy_ignore();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
